oam_dma_ram: RTL

Writable sprite attribute memory (OAM) that replaces the fixed per-game OAM dump ROMs. Holds NUM_SPR sprites of 4 bytes each: Y, tile, attribute, X.
- CPU port: address register with auto-increment, as NES $2003/$2004.
- DMA engine: copies a whole sprite table from a CPU page, as NES $4014.
- Renderer port: registered read for sprite evaluation.

---
 rtl/oam_pkg.sv | 35 +++
 rtl/oam_ram_1w2r.sv | 49 ++++
 rtl/oam_dma_ram.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/oam_pkg.sv
// ---------------------------------------------------------------------------
// oam_pkg
// Shared definitions for the writable sprite attribute memory (OAM).
// Each sprite is 4 bytes: Y, tile, attribute, X. Holds the byte offsets,
// the read mask for the attribute byte, the "hidden sprite" fill value and
// the DMA engine state type.
// Optional build macro used by the users of this package: OAM_INIT_EN.
// ---------------------------------------------------------------------------
package oam_pkg;

  localparam logic [1:0] OFS_Y    = 2'd0;
  localparam logic [1:0] OFS_TILE = 2'd1;
  localparam logic [1:0] OFS_ATTR = 2'd2;
  localparam logic [1:0] OFS_X    = 2'd3;

  // Attribute bits [4:2] do not exist in hardware and always read as 0.
  localparam logic [7:0] ATTR_RD_MASK = 8'hE3;

  // A Y coordinate of FF puts the sprite below the visible area.
  localparam logic [7:0] HIDE_Y = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    INIT
  } dma_state_t;

  // Read mask for a byte, selected by its offset within the sprite.
  function automatic logic [7:0] rd_mask(input logic [1:0] ofs);
    return (ofs == OFS_ATTR) ? ATTR_RD_MASK : 8'hFF;
  endfunction

endpackage

// File: rtl/oam_ram_1w2r.sv
// ---------------------------------------------------------------------------
// oam_ram_1w2r
// Byte-wide storage array with one write port and two registered read
// ports (CPU and renderer). Contents are not reset; only the read data
// registers are. A read and a write to the same address in one cycle
// return the old data.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   we, waddr, wdata        write port
//   cpu_re, cpu_raddr       CPU read strobe and address
//   cpu_rdata               CPU read data, valid the cycle after cpu_re
//   ppu_raddr, ppu_rdata    renderer read, read every cycle, 1-cycle latency
// ---------------------------------------------------------------------------
module oam_ram_1w2r #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_raddr,
  output logic [7:0]    cpu_rdata,
  input  logic [AW-1:0] ppu_raddr,
  output logic [7:0]    ppu_rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The CPU register holds its value between read strobes; the renderer
  // register follows ppu_raddr every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= 8'h00;
      ppu_rdata <= 8'h00;
    end else begin
      if (cpu_re) cpu_rdata <= mem[cpu_raddr];
      ppu_rdata <= mem[ppu_raddr];
    end
  end

endmodule

// File: rtl/oam_dma_ram.sv
// ---------------------------------------------------------------------------
// oam_dma_ram
// Writable sprite attribute memory of NUM_SPR sprites x 4 bytes.
//   - CPU port: address register with auto-increment on data writes.
//   - DMA engine: copies 4*NUM_SPR bytes from source page {dma_page,8'h00},
//     landing at the current oam_addr and wrapping; oam_addr ends where it
//     started. Cost is at least 2 cycles per byte.
//   - Renderer port: registered read every cycle, also during DMA.
// Attribute bytes read back with bits [4:2] cleared on both read ports.
//
// Build option: OAM_INIT_EN -- when defined, leaving reset runs an INIT
// pass writing 8'hFF to every byte (dma_busy high), hiding all sprites.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   oamaddr_we, oamdata_we, oamdata_re CPU strobes
//   cpu_wdata, cpu_rdata               CPU data (cpu_rdata registered)
//   dma_start, dma_page, dma_busy      DMA control / status
//   dma_rd_req, dma_rd_addr            source read request and address
//   dma_rd_ack, dma_rd_data            source data handshake
//   ppu_addr, ppu_dout                 renderer read port
// ---------------------------------------------------------------------------
module oam_dma_ram
  import oam_pkg::*;
#(
  parameter  int NUM_SPR = 64,
  parameter  int SRC_AW  = 16,
  localparam int AW      = $clog2(NUM_SPR * 4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oamaddr_we,
  input  logic              oamdata_we,
  input  logic              oamdata_re,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_start,
  input  logic [7:0]        dma_page,
  output logic              dma_busy,
  output logic              dma_rd_req,
  output logic [SRC_AW-1:0] dma_rd_addr,
  input  logic              dma_rd_ack,
  input  logic [7:0]        dma_rd_data,
  input  logic [AW-1:0]     ppu_addr,
  output logic [7:0]        ppu_dout
);

  localparam int        DEPTH = NUM_SPR * 4;
  localparam [AW-1:0]   LAST  = AW'(DEPTH - 1);

  dma_state_t         state;
  logic [AW-1:0]      oam_addr;
  logic [AW-1:0]      cnt;
  logic [SRC_AW-1:0]  base;

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [7:0]         wr_data;

  logic [7:0]         cpu_raw;
  logic [7:0]         ppu_raw;
  logic [7:0]         cpu_mask;
  logic [7:0]         ppu_mask;

  // Single write port shared by CPU, DMA and INIT; the FSM state decides
  // who owns it. A same-cycle address load drops the CPU data write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = oam_addr;
    wr_data = cpu_wdata;
    case (state)
      IDLE: wr_en = oamdata_we && !oamaddr_we;
      WAIT: begin
        wr_en   = dma_rd_ack;
        wr_data = dma_rd_data;
      end
`ifdef OAM_INIT_EN
      INIT: begin
        wr_en   = dma_busy;
        wr_addr = cnt;
        wr_data = HIDE_Y;
      end
`endif
      default: ;
    endcase
  end

  // DMA / INIT state machine. Also owns oam_addr, since both the CPU port
  // and the DMA advance it. CPU strobes only take effect in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef OAM_INIT_EN
      state <= INIT;
`else
      state <= IDLE;
`endif
      oam_addr    <= '0;
      cnt         <= '0;
      base        <= '0;
      dma_busy    <= 1'b0;
      dma_rd_req  <= 1'b0;
      dma_rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (oamaddr_we) oam_addr <= cpu_wdata[AW-1:0];
          else if (oamdata_we) oam_addr <= oam_addr + 1'b1;
          if (dma_start) begin
            base     <= SRC_AW'({dma_page, 8'h00});
            cnt      <= '0;
            dma_busy <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          dma_rd_req  <= 1'b1;
          dma_rd_addr <= base + SRC_AW'(cnt);
          state       <= WAIT;
        end
        WAIT: begin
          if (dma_rd_ack) begin
            dma_rd_req <= 1'b0;
            oam_addr   <= oam_addr + 1'b1;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST) begin
              dma_busy <= 1'b0;
              state    <= DONE;
            end else begin
              state <= REQ;
            end
          end
        end
        DONE: begin
          dma_busy   <= 1'b0;
          dma_rd_req <= 1'b0;
          state      <= IDLE;
        end
`ifdef OAM_INIT_EN
        // First INIT cycle only raises dma_busy, so busy stays high for
        // exactly one cycle per byte written.
        INIT: begin
          if (!dma_busy) begin
            dma_busy <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              dma_busy <= 1'b0;
              cnt      <= '0;
              state    <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Masks are registered alongside the read data so they line up with the
  // address that was actually read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_mask <= 8'hFF;
      ppu_mask <= 8'hFF;
    end else begin
      if (oamdata_re) cpu_mask <= rd_mask(oam_addr[1:0]);
      ppu_mask <= rd_mask(ppu_addr[1:0]);
    end
  end

  assign cpu_rdata = cpu_raw & cpu_mask;
  assign ppu_dout  = ppu_raw & ppu_mask;

  oam_ram_1w2r #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_en),
    .waddr    (wr_addr),
    .wdata    (wr_data),
    .cpu_re   (oamdata_re),
    .cpu_raddr(oam_addr),
    .cpu_rdata(cpu_raw),
    .ppu_raddr(ppu_addr),
    .ppu_rdata(ppu_raw)
  );

endmodule
